// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared FSM encodings and counter-width helper for serial_subtractor
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Never returns 0 so that WIDTH=1 / STEP_DIV=1 still get a legal vector width.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// rtl/serial_sub_cell.sv - combinational 1-bit full subtractor (a - b - bin)
module serial_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor with busy/done handshake and sticky underflow
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP_DIV = 1
) (
  input  logic             iCE_CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             clr_sticky,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             diff_bit,
  output logic             borrow_bit,
  output logic             underflow_latch
);

  localparam int IDX_W = clog2_min1(WIDTH);
  localparam int DIV_W = clog2_min1(STEP_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(STEP_DIV - 1);

  state_t            state, state_next;
  logic [WIDTH-1:0]  a_sr, b_sr, r_sr, r_next;
  logic              borrow;
  logic [IDX_W-1:0]  bit_idx;
  logic [DIV_W-1:0]  div_cnt;
  logic              cell_d, cell_bout;
  logic              step_tick, last_step;

  serial_sub_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign step_tick  = (state == ST_SHIFT) && (div_cnt == LAST_DIV);
  assign last_step  = step_tick && (bit_idx == LAST_IDX);
  assign borrow_bit = borrow;

  // Result is assembled MSB-down so the final step lands the last bit in diff directly.
  generate
    if (WIDTH == 1) begin : g_r_one
      assign r_next = cell_d;
    end else begin : g_r_wide
      assign r_next = {cell_d, r_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge iCE_CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_step) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCE_CLK) begin
    if (reset) begin
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      borrow     <= 1'b0;
      bit_idx    <= '0;
      div_cnt    <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      diff_bit   <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        a_sr    <= a_in;
        b_sr    <= b_in;
        borrow  <= 1'b0;
        bit_idx <= '0;
        div_cnt <= '0;
      end
    end else if (state == ST_SHIFT) begin
      if (step_tick) begin
        a_sr     <= a_sr >> 1;
        b_sr     <= b_sr >> 1;
        r_sr     <= r_next;
        borrow   <= cell_bout;
        diff_bit <= cell_d;
        bit_idx  <= bit_idx + IDX_W'(1);
        div_cnt  <= '0;
        if (last_step) begin
          diff       <= r_next;
          borrow_out <= cell_bout;
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Clear outranks a same-cycle set from an underflowing DONE.
  always_ff @(posedge iCE_CLK) begin
    if (reset || clr_sticky)                   underflow_latch <= 1'b0;
    else if (state == ST_DONE && borrow_out)   underflow_latch <= 1'b1;
  end

endmodule
